// File: rtl/karatsuba_pkg.sv
// Shared types and defaults for the Karatsuba multiplier issue/return controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package karatsuba_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int PROD_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } issue_state_t;

endpackage

// File: rtl/karatsuba_operand_fifo.sv
// Small synchronous FIFO buffering {A, B, tag} operand entries ahead of issue.
// Latency: a pushed entry is visible at head_dat the cycle after the push edge.
// Backpressure: full must gate push upstream; a simultaneous push and pop is allowed.
module karatsuba_operand_fifo #(
    parameter int WIDTH = 132,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_dat
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    assign full     = (r_count == CNT_FULL);
    assign empty    = (r_count == '0);
    assign head_dat = r_mem[r_rd_ptr];

    // Entry storage; contents are don't-care until counted valid, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping with wrap at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/karatsuba_issue_ctrl.sv
// Buffers operand pairs, issues one multiply at a time with held operands, returns product+tag.
// Latency: input handshake cycle 0 -> mul_start cycle 2; mul_valid cycle k -> out_valid cycle k+1.
// Backpressure: in_ready low when the 2-entry FIFO is full; result held in HOLD until out_ready.
module karatsuba_issue_ctrl
    import karatsuba_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                mul_start,
    output logic [DATA_W-1:0]   mul_a,
    output logic [DATA_W-1:0]   mul_b,
    input  logic [2*DATA_W-1:0] mul_p,
    input  logic                mul_valid,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_p,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err,
    output logic                busy
);

    localparam int ENT_W = 2 * DATA_W + TAG_W;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    issue_state_t        r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [TAG_W-1:0]    r_op_tag;
    logic                r_mul_start;
    logic                r_out_valid;
    logic [2*DATA_W-1:0] r_out_p;
    logic [TAG_W-1:0]    r_out_tag;
    logic                r_out_err;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [ENT_W-1:0]    w_push_dat;
    logic [ENT_W-1:0]    w_head;
    logic [DATA_W-1:0]   w_head_a;
    logic [DATA_W-1:0]   w_head_b;
    logic [TAG_W-1:0]    w_head_tag;

    // rst gates in_ready combinationally so nothing is accepted in a reset cycle.
    assign in_ready   = !w_full && !rst;
    assign w_push     = in_valid && in_ready;
    assign w_pop      = (r_state == IDLE) && !w_empty;
    assign w_push_dat = {in_a, in_b, in_tag};
    assign {w_head_a, w_head_b, w_head_tag} = w_head;

    assign busy      = (r_state != IDLE) || !w_empty;
    assign mul_start = r_mul_start;
    assign mul_a     = r_op_a;
    assign mul_b     = r_op_b;
    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign out_tag   = r_out_tag;
    assign out_err   = r_out_err;

    karatsuba_operand_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .push_dat (w_push_dat),
        .pop      (w_pop),
        .full     (w_full),
        .empty    (w_empty),
        .head_dat (w_head)
    );

    // Issue/wait/return sequencer; operand registers only load on IDLE->ISSUE so the
    // multiplier sees stable A/B for every sub-stage through the end of HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_tag    <= '0;
            r_mul_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_out_tag   <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_op_a      <= w_head_a;
                        r_op_b      <= w_head_b;
                        r_op_tag    <= w_head_tag;
                        r_mul_start <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mul_start <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A product arriving on the final timeout cycle still wins.
                    if (mul_valid) begin
                        r_out_p     <= mul_p;
                        r_out_err   <= 1'b0;
                        r_out_tag   <= r_op_tag;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else if (r_cnt == CNT_LAST) begin
                        r_out_p     <= '0;
                        r_out_err   <= 1'b1;
                        r_out_tag   <= r_op_tag;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba_issue_ctrl.sv
// Self-checking bench for karatsuba_issue_ctrl with a behavioural multiplier stub.
// Latency: n/a.
// Backpressure: out_ready is driven per scenario.
module tb_karatsuba_issue_ctrl;

    localparam int TMO = 16;
    localparam int M_NORMAL = 0;
    localparam int M_FIXED  = 1;
    localparam int M_NEVER  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_a;
    logic [63:0]  in_b;
    logic [3:0]   in_tag;
    logic         mul_start;
    logic [63:0]  mul_a;
    logic [63:0]  mul_b;
    logic [127:0] mul_p;
    logic         mul_valid;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_p;
    logic [3:0]   out_tag;
    logic         out_err;
    logic         busy;

    typedef struct {
        logic [127:0] p;
        logic [3:0]   tag;
        logic         err;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;

    int           stub_mode = M_NORMAL;
    int           stub_lat = 1;
    logic [127:0] stub_prod = '0;
    int           inject_req_n = 0;

    int   cyc_n = 0;
    int   start_cnt = 0;
    int   start_cyc = 0;
    int   mv_cyc = 0;
    int   ov_rise_cyc = 0;
    int   ov_rise_cnt = 0;
    int   hold_viol = 0;
    int   dbl_issue = 0;

    karatsuba_issue_ctrl #(
        .DATA_W      (64),
        .TAG_W       (4),
        .TIMEOUT_CYC (TMO),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .mul_valid (mul_valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Multiplier stub: answers a mul_start after a latency chosen by the current mode.
    initial begin : stub
        int pend;
        int inj_done;
        logic [127:0] pp;
        pend = -1;
        inj_done = 0;
        pp = '0;
        mul_valid = 1'b0;
        mul_p = '0;
        forever begin
            @(posedge clk);
            #1;
            mul_valid = 1'b0;
            if (rst) begin
                pend = -1;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        mul_valid = 1'b1;
                        mul_p = pp;
                        pend = -1;
                    end
                end
                if (mul_start) begin
                    if (stub_mode == M_NORMAL) begin
                        pend = $urandom_range(12, 1);
                        pp = {64'h0, mul_a} * {64'h0, mul_b};
                    end else if (stub_mode == M_FIXED) begin
                        pend = stub_lat;
                        pp = stub_prod;
                    end
                end
                if (inject_req_n != inj_done) begin
                    mul_valid = 1'b1;
                    mul_p = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
                    inj_done = inject_req_n;
                end
            end
        end
    end

    // Observation of issue timing, operand stability and result-valid edges.
    initial begin : mon
        logic prev_ov;
        logic in_op;
        logic [63:0] held_a;
        logic [63:0] held_b;
        prev_ov = 1'b0;
        in_op = 1'b0;
        held_a = '0;
        held_b = '0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (mul_valid) mv_cyc = cyc_n;
            if (out_valid === 1'b1 && !prev_ov) begin
                ov_rise_cyc = cyc_n;
                ov_rise_cnt++;
            end
            prev_ov = (out_valid === 1'b1);
            if (rst) begin
                in_op = 1'b0;
            end else begin
                if (mul_start) begin
                    start_cnt++;
                    start_cyc = cyc_n;
                    if (in_op) dbl_issue++;
                    in_op = 1'b1;
                    held_a = mul_a;
                    held_b = mul_b;
                end else if (in_op && (mul_a !== held_a || mul_b !== held_b)) begin
                    hold_viol++;
                end
                if (out_valid && out_ready) in_op = 1'b0;
            end
        end
    end

    // Reference: product arriving within TMO WAIT cycles wins, otherwise zero with error.
    function automatic exp_t model_result(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] t);
        exp_t e;
        e.tag = t;
        if (stub_mode == M_NORMAL) begin
            e.p = {64'h0, a} * {64'h0, b};
            e.err = 1'b0;
        end else if (stub_mode == M_FIXED && stub_lat <= TMO) begin
            e.p = stub_prod;
            e.err = 1'b0;
        end else begin
            e.p = '0;
            e.err = 1'b1;
        end
        return e;
    endfunction

    task automatic push_op(input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] t, output int hs);
        int n;
        n = 0;
        in_a = a;
        in_b = b;
        in_tag = t;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL push_accept in_ready=%0b required=1 after %0d cycles", in_ready, n);
            hs = -1;
        end else begin
            hs = cyc_n + 1;
            exp_q.push_back(model_result(a, b, t));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic get_result(output exp_t r, output bit got);
        int n;
        n = 0;
        got = 1'b0;
        r.p = '0;
        r.tag = '0;
        r.err = 1'b0;
        while (n < 200 && !got) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                r.p = out_p;
                r.tag = out_tag;
                r.err = out_err;
                got = 1'b1;
            end
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b exp=0", in_ready);
        end
        checks++;
        if ({mul_start, mul_a, mul_b, out_valid, out_p, out_tag, out_err, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs start=%0b a=%0h b=%0h ov=%0b p=%0h tag=%0h err=%0b busy=%0b exp all 0",
                     mul_start, mul_a, mul_b, out_valid, out_p, out_tag, out_err, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        exp_t r;
        exp_t e;
        bit got;
        int hs;
        int s0;
        stub_mode = M_NORMAL;
        out_ready = 1'b1;
        s0 = start_cnt;
        push_op(64'd3, 64'd5, 4'd7, hs);
        get_result(r, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || r.p !== 128'd15 || r.p !== e.p) begin
            failures++;
            $display("FAIL basic_p got=%0h exp=15 (valid seen=%0b)", r.p, got);
        end
        checks++;
        if (r.tag !== 4'd7 || r.err !== 1'b0) begin
            failures++;
            $display("FAIL basic_tag_err tag=%0h err=%0b exp tag=7 err=0", r.tag, r.err);
        end
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL basic_start_count got=%0d exp=1", start_cnt - s0);
        end
        checks++;
        if (start_cyc != hs + 2) begin
            failures++;
            $display("FAIL basic_start_latency got=%0d exp=%0d", start_cyc - hs, 2);
        end
        checks++;
        if (ov_rise_cyc != mv_cyc + 1) begin
            failures++;
            $display("FAIL basic_out_latency got=%0d exp=1", ov_rise_cyc - mv_cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_max_operands();
        exp_t r;
        exp_t e;
        bit got;
        int hs;
        stub_mode = M_NORMAL;
        out_ready = 1'b1;
        push_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'hA, hs);
        get_result(r, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || r.p !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 || r.p !== e.p) begin
            failures++;
            $display("FAIL max_p got=%0h exp=fffffffffffffffe0000000000000001", r.p);
        end
        checks++;
        if (r.err !== 1'b0 || r.tag !== 4'hA) begin
            failures++;
            $display("FAIL max_err_tag err=%0b tag=%0h exp err=0 tag=a", r.err, r.tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        exp_t r;
        exp_t e;
        bit got;
        int hs;
        stub_mode = M_NORMAL;
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            push_op({$urandom, $urandom}, {$urandom, $urandom}, 4'(i), hs);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_full in_ready=%0b busy=%0b exp in_ready=0 busy=1", in_ready, busy);
        end
        repeat ($urandom_range(20, 2)) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_still_full in_ready=%0b exp=0", in_ready);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            get_result(r, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || r.p !== e.p || r.tag !== 4'(i) || r.err !== 1'b0) begin
                failures++;
                $display("FAIL b2b_result%0d p=%0h tag=%0h err=%0b exp p=%0h tag=%0h err=0",
                         i, r.p, r.tag, r.err, e.p, i);
            end
        end
        checks++;
        if (hold_viol != 0) begin
            failures++;
            $display("FAIL b2b_operand_hold changes=%0d exp=0", hold_viol);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        exp_t r;
        exp_t e;
        bit got;
        int hs;
        logic [63:0] a;
        logic [63:0] b;
        stub_mode = M_NORMAL;
        for (int i = 0; i < 6; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i == 0) a = '0;
            if (i == 1) b = 64'd1;
            out_ready = 1'b0;
            push_op(a, b, 4'($urandom_range(15, 0)), hs);
            repeat ($urandom_range(25, 0)) @(posedge clk);
            #1;
            out_ready = 1'b1;
            get_result(r, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || r.p !== e.p || r.tag !== e.tag || r.err !== e.err) begin
                failures++;
                $display("FAIL random%0d p=%0h tag=%0h err=%0b exp p=%0h tag=%0h err=%0b",
                         i, r.p, r.tag, r.err, e.p, e.tag, e.err);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_timeout();
        exp_t r;
        exp_t e;
        bit got;
        int hs;
        int n;
        int ov0;
        stub_mode = M_NEVER;
        out_ready = 1'b0;
        push_op(64'h1234, 64'h5678, 4'd9, hs);
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL timeout_valid out_valid=%0b exp=1 within 100 cycles", out_valid);
        end
        checks++;
        if (ov_rise_cyc != start_cyc + TMO + 1) begin
            failures++;
            $display("FAIL timeout_cycles wait=%0d exp=%0d", ov_rise_cyc - start_cyc - 1, TMO);
        end
        checks++;
        if (out_p !== '0 || out_err !== 1'b1 || out_tag !== 4'd9) begin
            failures++;
            $display("FAIL timeout_result p=%0h err=%0b tag=%0h exp p=0 err=1 tag=9", out_p, out_err, out_tag);
        end
        @(posedge clk);
        #1;
        inject_req_n++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_p !== '0) begin
            failures++;
            $display("FAIL late_valid_hold ov=%0b err=%0b p=%0h exp ov=1 err=1 p=0", out_valid, out_err, out_p);
        end
        out_ready = 1'b1;
        get_result(r, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || r.p !== e.p || r.err !== e.err || r.tag !== e.tag) begin
            failures++;
            $display("FAIL timeout_handshake p=%0h err=%0b tag=%0h exp p=%0h err=%0b tag=%0h",
                     r.p, r.err, r.tag, e.p, e.err, e.tag);
        end
        @(posedge clk);
        #1;
        ov0 = ov_rise_cnt;
        inject_req_n++;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ov_rise_cnt != ov0) begin
            failures++;
            $display("FAIL late_valid_idle ov=%0b busy=%0b rises=%0d exp ov=0 busy=0 rises=0",
                     out_valid, busy, ov_rise_cnt - ov0);
        end
        stub_mode = M_NORMAL;
        push_op(64'd1000, 64'd77, 4'd4, hs);
        get_result(r, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || r.p !== 128'd77000 || r.p !== e.p || r.err !== 1'b0 || r.tag !== 4'd4) begin
            failures++;
            $display("FAIL after_timeout p=%0h err=%0b tag=%0h exp p=12cc8 err=0 tag=4", r.p, r.err, r.tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout_race();
        exp_t r;
        exp_t e;
        bit got;
        int hs;
        stub_mode = M_FIXED;
        stub_prod = 128'hABCD;
        stub_lat = TMO;
        out_ready = 1'b1;
        push_op(64'd11, 64'd13, 4'd5, hs);
        get_result(r, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || r.p !== 128'hABCD || r.p !== e.p || r.err !== 1'b0) begin
            failures++;
            $display("FAIL race_product_wins p=%0h err=%0b exp p=abcd err=0", r.p, r.err);
        end
        checks++;
        if (mv_cyc != start_cyc + TMO || ov_rise_cyc != start_cyc + TMO + 1) begin
            failures++;
            $display("FAIL race_timing strobe=%0d valid=%0d exp strobe=%0d valid=%0d",
                     mv_cyc - start_cyc, ov_rise_cyc - start_cyc, TMO, TMO + 1);
        end
        @(posedge clk);
        #1;
        stub_lat = TMO + 1;
        out_ready = 1'b0;
        push_op(64'd11, 64'd13, 4'd6, hs);
        repeat (TMO + 8) @(posedge clk);
        #1;
        out_ready = 1'b1;
        get_result(r, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || r.p !== e.p || r.err !== 1'b1 || r.tag !== 4'd6) begin
            failures++;
            $display("FAIL race_one_late p=%0h err=%0b tag=%0h exp p=0 err=1 tag=6", r.p, r.err, r.tag);
        end
        stub_mode = M_NORMAL;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        exp_t r;
        exp_t e;
        bit got;
        int hs;
        int ov0;
        int s0;
        stub_mode = M_NEVER;
        out_ready = 1'b1;
        push_op(64'd21, 64'd2, 4'd1, hs);
        push_op(64'd31, 64'd3, 4'd2, hs);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_reset busy=%0b in_ready=%0b exp busy=1 in_ready=1", busy, in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_in_ready got=%0b exp=0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({mul_start, mul_a, mul_b, out_valid, out_p, out_tag, out_err, busy} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs start=%0b a=%0h b=%0h ov=%0b p=%0h tag=%0h err=%0b busy=%0b exp all 0",
                     mul_start, mul_a, mul_b, out_valid, out_p, out_tag, out_err, busy);
        end
        rst = 1'b0;
        exp_q.delete();
        ov0 = ov_rise_cnt;
        s0 = start_cnt;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (ov_rise_cnt != ov0 || start_cnt != s0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_quiet rises=%0d starts=%0d busy=%0b exp 0 0 0",
                     ov_rise_cnt - ov0, start_cnt - s0, busy);
        end
        stub_mode = M_NORMAL;
        push_op(64'd40, 64'd50, 4'hC, hs);
        get_result(r, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || r.p !== 128'd2000 || r.p !== e.p || r.tag !== 4'hC || r.err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_fresh p=%0h tag=%0h err=%0b exp p=7d0 tag=c err=0", r.p, r.tag, r.err);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish in time checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin : main
        test_reset();
        test_basic();
        test_max_operands();
        test_back_to_back();
        test_random();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        checks++;
        if (hold_viol != 0 || dbl_issue != 0) begin
            failures++;
            $display("FAIL global_issue_rules hold_changes=%0d double_issue=%0d exp 0 0", hold_viol, dbl_issue);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
